// File: rtl/lane_rr_pkg.sv
// Shared types and helpers for the lane round-robin scheduler.
// The optional hold timeout is enabled by defining LANE_RR_TIMEOUT_EN.
package lane_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } lane_rr_state_e;

    localparam int CNT_W = 8;

    // Lane index width; a single lane still gets a one-bit index.
    function automatic int idw_f(input int wid);
        return (wid <= 2) ? 1 : $clog2(wid);
    endfunction

endpackage

// File: rtl/lane_rr_pick.sv
// Combinational rotating-priority picker: first requesting lane at or after
// start, wrapping modulo WID.
module lane_rr_pick
    import lane_rr_pkg::*;
#(
    parameter int WID = 5,
    parameter int IDW = idw_f(WID)
) (
    input  logic [WID-1:0] req,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [WID-1:0] pick,
    output logic [IDW-1:0] idx
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] lane;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        sum   = '0;
        lane  = '0;
        for (int k = 0; k < WID; k++) begin
            // Wrap at WID so unused index codes of a non-power-of-two array are never visited.
            sum = {1'b0, start} + SW'(k);
            if (sum >= SW'(WID)) begin
                sum = sum - SW'(WID);
            end
            lane = sum[IDW-1:0];
            if (!found && req[lane]) begin
                found      = 1'b1;
                pick[lane] = 1'b1;
                idx        = lane;
            end
        end
    end

endmodule

// File: rtl/lane_rr_sched.sv
// Round-robin scheduler granting one lane at a time until done, no bubble on handoff.
// Optional forced release after TIMEOUT hold cycles when LANE_RR_TIMEOUT_EN is defined.
module lane_rr_sched
    import lane_rr_pkg::*;
#(
    parameter int WID     = 5,
    parameter int TIMEOUT = 15,
    localparam int IDW    = idw_f(WID)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] req,
    input  logic           enable,
    input  logic           done,
    output logic [WID-1:0] grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout_pulse,
    output lane_rr_state_e state
);

    // Handshake: a lane owns the slot from the edge grant rises until the edge
    // that samples done=1; done is ignored whenever no grant is held.

    if (WID < 1 || WID > 32) begin : g_bad_wid
        $error("lane_rr_sched: WID out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("lane_rr_sched: TIMEOUT out of range");
    end

    lane_rr_state_e cur_state, nxt_state;
    logic [WID-1:0] grant_q, nxt_grant;
    logic [IDW-1:0] grant_id_q, nxt_grant_id;
    logic [IDW-1:0] last_q, nxt_last;
    logic           timeout_q, nxt_timeout;

    logic [IDW-1:0] base_id;
    logic [IDW-1:0] start_id;
    logic           found;
    logic [WID-1:0] pick;
    logic [IDW-1:0] pick_id;
    logic           expired;

    // While holding, the current holder becomes lowest priority for a same-edge handoff.
    assign base_id  = (cur_state == HOLD) ? grant_id_q : last_q;
    assign start_id = (base_id == IDW'(WID - 1)) ? '0 : base_id + IDW'(1);

    lane_rr_pick #(
        .WID (WID),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .start (start_id),
        .found (found),
        .pick  (pick),
        .idx   (pick_id)
    );

`ifdef LANE_RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, nxt_cnt;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= nxt_cnt;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        nxt_state    = cur_state;
        nxt_grant    = grant_q;
        nxt_grant_id = grant_id_q;
        nxt_last     = last_q;
        nxt_timeout  = 1'b0;
`ifdef LANE_RR_TIMEOUT_EN
        nxt_cnt      = cnt_q;
`endif
        unique case (cur_state)
            IDLE: begin
                if (enable && found) begin
                    nxt_state    = HOLD;
                    nxt_grant    = pick;
                    nxt_grant_id = pick_id;
`ifdef LANE_RR_TIMEOUT_EN
                    nxt_cnt      = '0;
`endif
                end
            end
            HOLD: begin
                if (done) begin
                    nxt_last = grant_id_q;
                    if (enable && found) begin
                        nxt_grant    = pick;
                        nxt_grant_id = pick_id;
`ifdef LANE_RR_TIMEOUT_EN
                        nxt_cnt      = '0;
`endif
                    end else begin
                        nxt_state = IDLE;
                        nxt_grant = '0;
                    end
                end else if (expired) begin
                    nxt_last    = grant_id_q;
                    nxt_state   = IDLE;
                    nxt_grant   = '0;
                    nxt_timeout = 1'b1;
                end else begin
`ifdef LANE_RR_TIMEOUT_EN
                    nxt_cnt = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_q     <= IDW'(WID - 1);
            timeout_q  <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            grant_q    <= nxt_grant;
            grant_id_q <= nxt_grant_id;
            last_q     <= nxt_last;
            timeout_q  <= nxt_timeout;
        end
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign busy          = |grant_q;
    assign timeout_pulse = timeout_q;
    assign state         = cur_state;

endmodule

// File: doc/lane_rr_sched.md
# lane_rr_sched

Round-robin scheduler that shares a single service slot among a parameterized array of WID lanes (one per element of a generate-built instance array). Each cycle it examines the lane request vector, grants exactly one lane with a one-hot grant held until the lane signals completion, and rotates priority so no lane starves. It sits between the per-lane instances and the shared resource they take turns on; its grant bits drive the per-lane strobes.

## Interface
- WID, default 5: number of lanes; legal range 1..32.
- TIMEOUT, default 15: maximum grant hold in cycles before forced release; legal range 1..255; used only with LANE_RR_TIMEOUT_EN.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  WID  per-lane request level; bit i = lane i wants service.
- enable  in  1  permits new grants; never cuts a grant already held.
- done  in  1  completion pulse from the granted lane; ignored when no grant is held.
- grant  out  WID  one-hot grant (or all zero), registered.
- grant_id  out  IDW  binary index of granted lane; IDW = max(1, clog2(WID)); value is don't-care when busy=0 but held at last value.
- busy  out  1  high while any grant is held; equals |grant.
- timeout_pulse  out  1  one-cycle pulse on forced release.

## Operation
- State machine, two states: IDLE (no grant), HOLD (one lane granted).
- Priority pointer `last` holds the most recently granted lane; search order is last+1, last+2, ... wrapping modulo WID, with `last` itself lowest priority.
- IDLE -> HOLD: enable=1 and req != 0; grant the first requesting lane in search order.
- IDLE with enable=0 or req=0: stay; outputs unchanged.
- HOLD, done=1: release; `last` <= grant_id. If enable=1 and any req bit set (granted lane's own bit counted at lowest priority), grant the next lane on the same edge and stay in HOLD (no bubble); otherwise -> IDLE with grant=0.
- HOLD, done=0: grant held regardless of req (granted lane dropping req does not release) and regardless of enable.
- Non-power-of-two WID: pointer increment wraps at WID-1 -> 0, never indexes unused codes.
- WID=1: lane 0 regranted back-to-back whenever req[0]=1 at done.

## Timing
- Reset values: grant=0, grant_id=0, busy=0, timeout_pulse=0, state IDLE, `last`=WID-1 (first search starts at lane 0), hold counter 0.
- Reset asserted mid-HOLD: grant drops asynchronously; no timeout_pulse.
- Grant latency: req/enable sampled at edge N, grant visible after edge N (1 cycle).
- done sampled at edge M: grant clears or moves to next lane after edge M.
- done and timeout expiry on the same edge: done wins; timeout_pulse stays 0.

## Configuration
- LANE_RR_TIMEOUT_EN defined: 8-bit hold counter cleared on each new grant, incremented each HOLD cycle without done; when it reaches TIMEOUT the grant is released, `last` <= grant_id, timeout_pulse=1 for one cycle, state -> IDLE (no same-edge regrant; next grant earliest one cycle later).
- Undefined: no counter logic; timeout_pulse tied 0; a grant is held until done indefinitely.

## Structure
- Package lane_rr_pkg: state enum type (IDLE, HOLD), IDW width function, counter width constant (8).
- One sub-module, lane_rr_pick: combinational rotating priority picker; inputs req vector and start index, outputs found flag, one-hot pick and binary index. Top module holds FSM, pointer, counter, output registers.

## Test plan
- Reset then req=5'b00000 with enable=1 for 10 cycles -> grant=0, busy=0 throughout.
- WID=5, req=5'b11111, done pulsed each cycle after grant -> grant sequence 00001, 00010, 00100, 01000, 10000, 00001 back-to-back, no idle cycles.
- req=5'b10010, done after 3 cycles each -> lanes 1, 4, 1, 4 alternate; grant_id 1, 4, 1, 4; each grant held exactly until done.
- Grant lane 2, then drop req[2] and enable for 5 cycles, no done -> grant stays 00100; done with enable=0 -> grant=0, IDLE; re-enable with req=5'b00101 -> lane 0 granted (search resumes at lane 3, wraps).
- With LANE_RR_TIMEOUT_EN, TIMEOUT=4: grant lane 0, never pulse done -> grant clears after 4 HOLD cycles, timeout_pulse=1 one cycle, next grant goes to next requester one cycle later; done coincident with expiry -> no timeout_pulse.
- Assert rst_n=0 mid-HOLD on lane 3 -> grant=0 immediately; after release with req=5'b01000 -> lane 3 granted, grant_id=3.
